// File: rtl/debounce_multi.sv
// debounce_multi: N-channel switch/button debouncer.
// Each channel has its own 4-state FSM and down-counter. Counting is paced
// by a shared strobe (tick_en_i), so one prescaler serves all channels.
// Outputs per channel: registered level, one-cycle rise and fall pulses.
// any_change_o is a registered OR of every rise/fall bit.
// Optional feature macro: DEBOUNCE_SYNC_EN adds a 2-flop synchronizer per
// input bit (+2 cycles latency). Undefined: sw_i must already be synchronous.

// One debouncer channel. Outputs are registered. change_nxt is the
// pre-register rise|fall so the top can register any_change in the same cycle.
module debounce_lane #(
    parameter int DB_TICKS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_en,
    input  logic s,
    output logic level,
    output logic rise,
    output logic fall,
    output logic change_nxt
);
    localparam int CNT_W = $clog2(DB_TICKS + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DB_TICKS - 1);

    // ONE and WAIT0 share bit 1 so the level is simply "state is 1x".
    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b11,
        WAIT0 = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rise_nxt, fall_nxt, level_nxt;

    // Next-state / counter logic. A wait state only moves on an enabled
    // strobe; any return of the input to the settled value aborts the wait.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            ZERO: begin
                if (s) begin
                    state_nxt = WAIT1;
                    cnt_nxt   = RELOAD;
                end
            end
            WAIT1: begin
                if (!s) begin
                    state_nxt = ZERO;
                end else if (tick_en) begin
                    if (cnt == '0) begin
                        state_nxt = ONE;
                        rise_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
            end
            ONE: begin
                if (!s) begin
                    state_nxt = WAIT0;
                    cnt_nxt   = RELOAD;
                end
            end
            WAIT0: begin
                if (s) begin
                    state_nxt = ONE;
                end else if (tick_en) begin
                    if (cnt == '0) begin
                        state_nxt = ZERO;
                        fall_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
            end
            default: state_nxt = ZERO;
        endcase
    end

    assign level_nxt  = (state_nxt == ONE) || (state_nxt == WAIT0);
    assign change_nxt = rise_nxt | fall_nxt;

    // State, counter and registered outputs; reset discards any progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ZERO;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end
endmodule

module debounce_multi #(
    parameter int CHANNELS = 4,
    parameter int DB_TICKS = 20
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tick_en_i,
    input  logic [CHANNELS-1:0] sw_i,
    output logic [CHANNELS-1:0] db_level_o,
    output logic [CHANNELS-1:0] db_rise_o,
    output logic [CHANNELS-1:0] db_fall_o,
    output logic                any_change_o
);
    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] change_nxt;

`ifdef DEBOUNCE_SYNC_EN
    logic [CHANNELS-1:0] sync_q1, sync_q2;

    // Two-flop synchronizer for inputs taken straight from pins.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= sw_i;
            sync_q2 <= sync_q1;
        end
    end

    assign s = sync_q2;
`else
    assign s = sw_i;
`endif

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        debounce_lane #(
            .DB_TICKS (DB_TICKS)
        ) u_lane (
            .clk        (clk_i),
            .rst_n      (rst_ni),
            .tick_en    (tick_en_i),
            .s          (s[k]),
            .level      (db_level_o[k]),
            .rise       (db_rise_o[k]),
            .fall       (db_fall_o[k]),
            .change_nxt (change_nxt[k])
        );
    end

    // Single pulse covering every channel that changes in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            any_change_o <= 1'b0;
        end else begin
            any_change_o <= |change_nxt;
        end
    end
endmodule
